// File: rtl/snake_head_ctrl_if.sv
// Handshake bundle between the key/direction source and the snake head controller.
interface snake_head_ctrl_if #(
   parameter int unsigned X_W = 6,
   parameter int unsigned Y_W = 5
);
   logic [1:0]     dir_in;
   logic           dir_valid;
   logic           start;
   logic           pause;
   logic [X_W-1:0] head_x;
   logic [Y_W-1:0] head_y;
   logic [1:0]     cur_dir;
   logic           step_pulse;
   logic           game_over;
   logic [1:0]     state;

   modport master (
      output dir_in, dir_valid, start, pause,
      input  head_x, head_y, cur_dir, step_pulse, game_over, state
   );

   modport slave (
      input  dir_in, dir_valid, start, pause,
      output head_x, head_y, cur_dir, step_pulse, game_over, state
   );
endinterface

// File: rtl/snake_head_ctrl.sv
// Snake head position controller: latches turns, steps once per game tick,
// detects wall hits and holds the game state.
// Direction encoding: TOP=0, DOWN=1, LEFT=2, RIGHT=3 (opposite = bit0 flipped).
module snake_head_ctrl #(
   parameter int unsigned GRID_W   = 40,
   parameter int unsigned GRID_H   = 30,
   parameter int unsigned X_W      = 6,
   parameter int unsigned Y_W      = 5,
   parameter logic [23:0] TICK_MAX = 24'd4_999_999,
   parameter int unsigned START_X  = 20,
   parameter int unsigned START_Y  = 15
) (
   input logic               sys_clk,
   input logic               sys_rst_n,
   snake_head_ctrl_if.slave  bus
);

   localparam int unsigned CNT_W = 24;
   localparam logic [1:0] TOP_DIR   = 2'd0;
   localparam logic [1:0] DOWN_DIR  = 2'd1;
   localparam logic [1:0] LEFT_DIR  = 2'd2;
   localparam logic [1:0] RIGHT_DIR = 2'd3;
   localparam logic [X_W-1:0] X_START = X_W'(START_X);
   localparam logic [Y_W-1:0] Y_START = Y_W'(START_Y);
   localparam logic [X_W-1:0] X_LAST  = X_W'(GRID_W - 1);
   localparam logic [Y_W-1:0] Y_LAST  = Y_W'(GRID_H - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2,
      DEAD  = 2'd3
   } state_t;

   state_t         state_q, state_nxt;
   logic [X_W-1:0] head_x_q, head_x_nxt;
   logic [Y_W-1:0] head_y_q, head_y_nxt;
   logic [1:0]     cur_dir_q, cur_dir_nxt;
   logic [1:0]     pending_q, pending_nxt;
   logic [CNT_W-1:0] cnt_q, cnt_nxt;
   logic           step_q, step_nxt;
   logic           over_q, over_nxt;

   logic           wall_hit;
   logic [X_W-1:0] move_x;
   logic [Y_W-1:0] move_y;

   // Bounds check and candidate position, both from the latched request.
   always_comb begin
      wall_hit = 1'b0;
      move_x   = head_x_q;
      move_y   = head_y_q;
      case (pending_q)
         TOP_DIR: begin
            wall_hit = (head_y_q == '0);
            move_y   = head_y_q - Y_W'(1);
         end
         DOWN_DIR: begin
            wall_hit = (head_y_q == Y_LAST);
            move_y   = head_y_q + Y_W'(1);
         end
         LEFT_DIR: begin
            wall_hit = (head_x_q == '0);
            move_x   = head_x_q - X_W'(1);
         end
         default: begin
            wall_hit = (head_x_q == X_LAST);
            move_x   = head_x_q + X_W'(1);
         end
      endcase
   end

   // Next-state, turn acceptance, tick counter and step generation.
   always_comb begin
      state_nxt   = state_q;
      head_x_nxt  = head_x_q;
      head_y_nxt  = head_y_q;
      cur_dir_nxt = cur_dir_q;
      pending_nxt = pending_q;
      cnt_nxt     = cnt_q;
      step_nxt    = 1'b0;
      over_nxt    = over_q;

      // Reversal check is against the direction actually travelled.
      if (state_q != DEAD && bus.dir_valid && bus.dir_in != (cur_dir_q ^ 2'b01)) begin
         pending_nxt = bus.dir_in;
      end

      case (state_q)
         IDLE, DEAD: begin
            if (bus.start) begin
               state_nxt   = RUN;
               head_x_nxt  = X_START;
               head_y_nxt  = Y_START;
               cur_dir_nxt = TOP_DIR;
               pending_nxt = TOP_DIR;
               cnt_nxt     = '0;
               over_nxt    = 1'b0;
            end
         end
         RUN: begin
            if (bus.pause) begin
               state_nxt = PAUSE;
            end else if (cnt_q == TICK_MAX) begin
               cnt_nxt = '0;
               if (wall_hit) begin
                  state_nxt = DEAD;
                  over_nxt  = 1'b1;
               end else begin
                  head_x_nxt  = move_x;
                  head_y_nxt  = move_y;
                  cur_dir_nxt = pending_q;
                  step_nxt    = 1'b1;
               end
            end else begin
               cnt_nxt = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            if (!bus.pause) state_nxt = RUN;
         end
      endcase
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         state_q   <= IDLE;
         head_x_q  <= X_START;
         head_y_q  <= Y_START;
         cur_dir_q <= TOP_DIR;
         pending_q <= TOP_DIR;
         cnt_q     <= '0;
         step_q    <= 1'b0;
         over_q    <= 1'b0;
      end else begin
         state_q   <= state_nxt;
         head_x_q  <= head_x_nxt;
         head_y_q  <= head_y_nxt;
         cur_dir_q <= cur_dir_nxt;
         pending_q <= pending_nxt;
         cnt_q     <= cnt_nxt;
         step_q    <= step_nxt;
         over_q    <= over_nxt;
      end
   end

   assign bus.head_x     = head_x_q;
   assign bus.head_y     = head_y_q;
   assign bus.cur_dir    = cur_dir_q;
   assign bus.step_pulse = step_q;
   assign bus.game_over  = over_q;
   assign bus.state      = state_q;

endmodule

// File: tb/tb_snake_head_ctrl.sv
// Directed testbench for snake_head_ctrl with a short tick period.
module tb_snake_head_ctrl;

   localparam logic [1:0] TOP_DIR   = 2'd0;
   localparam logic [1:0] DOWN_DIR  = 2'd1;
   localparam logic [1:0] LEFT_DIR  = 2'd2;
   localparam logic [1:0] RIGHT_DIR = 2'd3;

   logic sys_clk = 1'b0;
   logic sys_rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;
   int   cyc;
   logic saw_step;

   snake_head_ctrl_if #(.X_W(6), .Y_W(5)) bus ();

   snake_head_ctrl #(
      .GRID_W(40), .GRID_H(30), .X_W(6), .Y_W(5),
      .TICK_MAX(24'd3), .START_X(20), .START_Y(15)
   ) dut (
      .sys_clk  (sys_clk),
      .sys_rst_n(sys_rst_n),
      .bus      (bus)
   );

   always #5 sys_clk = ~sys_clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic send_dir(input logic [1:0] d);
      bus.dir_in    = d;
      bus.dir_valid = 1'b1;
      tick();
      bus.dir_valid = 1'b0;
   endtask

   // Advance until a step pulse is seen; returns edges taken, 0 on timeout.
   task automatic wait_step(output int n);
      n = 0;
      for (int i = 1; i <= 20; i++) begin
         tick();
         if (bus.step_pulse) begin
            n = i;
            break;
         end
      end
      if (n == 0) check("step_timeout", 32'd0, 32'd1);
   endtask

   task automatic check_head(input string tag, input int x, input int y);
      check({tag, "_x"}, 32'(bus.head_x), 32'(x));
      check({tag, "_y"}, 32'(bus.head_y), 32'(y));
   endtask

   initial begin
      bus.dir_in = TOP_DIR;
      bus.dir_valid = 1'b0;
      bus.start = 1'b0;
      bus.pause = 1'b0;

      // Reset values
      tick(); tick();
      check("rst_state", 32'(bus.state), 32'd0);
      check_head("rst", 20, 15);
      check("rst_dir", 32'(bus.cur_dir), 32'(TOP_DIR));
      check("rst_step", 32'(bus.step_pulse), 32'd0);
      check("rst_over", 32'(bus.game_over), 32'd0);

      // Start and basic upward steps every 4 cycles
      sys_rst_n = 1'b1;
      tick();
      check("idle_hold", 32'(bus.state), 32'd0);
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      check("start_state", 32'(bus.state), 32'd1);
      check_head("start", 20, 15);
      for (int s = 1; s <= 2; s++) begin
         wait_step(cyc);
         check("step_period", 32'(cyc), 32'd4);
         check_head("up", 20, 15 - s);
         check("up_dir", 32'(bus.cur_dir), 32'(TOP_DIR));
      end
      tick();
      check("pulse_width", 32'(bus.step_pulse), 32'd0);

      // Reversal rejected, then a valid left turn
      send_dir(DOWN_DIR);
      wait_step(cyc);
      check_head("rev", 20, 12);
      check("rev_dir", 32'(bus.cur_dir), 32'(TOP_DIR));
      send_dir(LEFT_DIR);
      wait_step(cyc);
      check_head("left", 19, 12);
      check("left_dir", 32'(bus.cur_dir), 32'(LEFT_DIR));

      // Two turns in one tick: second one is a reversal of cur_dir
      send_dir(TOP_DIR);
      send_dir(RIGHT_DIR);
      wait_step(cyc);
      check_head("dbl", 19, 11);
      check("dbl_dir", 32'(bus.cur_dir), 32'(TOP_DIR));

      // Run into the left wall
      send_dir(LEFT_DIR);
      for (int s = 0; s < 19; s++) wait_step(cyc);
      check_head("edge", 0, 11);
      saw_step = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (bus.step_pulse) saw_step = 1'b1;
         if (bus.state == 2'd3) break;
      end
      check("dead_state", 32'(bus.state), 32'd3);
      check("dead_over", 32'(bus.game_over), 32'd1);
      check("dead_nostep", 32'(saw_step), 32'd0);
      check_head("dead", 0, 11);
      send_dir(RIGHT_DIR);
      for (int i = 0; i < 6; i++) tick();
      check("dead_hold", 32'(bus.state), 32'd3);
      check_head("dead_hold", 0, 11);

      // Restart from DEAD
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      check("restart_state", 32'(bus.state), 32'd1);
      check("restart_over", 32'(bus.game_over), 32'd0);
      check("restart_dir", 32'(bus.cur_dir), 32'(TOP_DIR));
      check_head("restart", 20, 15);

      // Pause with counter at 2; counter resumes where it stopped
      tick(); tick();
      bus.pause = 1'b1;
      saw_step = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (bus.step_pulse) saw_step = 1'b1;
      end
      check("pause_state", 32'(bus.state), 32'd2);
      check("pause_nostep", 32'(saw_step), 32'd0);
      check_head("pause", 20, 15);
      bus.pause = 1'b0;
      wait_step(cyc);
      check("resume_edges", 32'(cyc), 32'd3);
      check_head("resume", 20, 14);

      // Walk to (25,10), then reset mid-run
      send_dir(RIGHT_DIR);
      for (int s = 0; s < 5; s++) wait_step(cyc);
      send_dir(TOP_DIR);
      for (int s = 0; s < 4; s++) wait_step(cyc);
      check_head("pre_rst", 25, 10);
      sys_rst_n = 1'b0;
      tick();
      sys_rst_n = 1'b1;
      check("mid_rst_state", 32'(bus.state), 32'd0);
      check_head("mid_rst", 20, 15);
      check("mid_rst_dir", 32'(bus.cur_dir), 32'(TOP_DIR));
      check("mid_rst_step", 32'(bus.step_pulse), 32'd0);
      check("mid_rst_over", 32'(bus.game_over), 32'd0);
      for (int i = 0; i < 6; i++) tick();
      check("idle_no_tick", 32'(bus.step_pulse), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
